// File: rtl/fb_pkg.sv
// Shared defaults, width derivations and writer indices for the framebuffer arbiter.
package fb_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_DATA_W    = 12;
  localparam int NUM_WRITERS   = 2;

  typedef enum logic [0:0] {
    WR_CPU  = 1'b0,
    WR_BLIT = 1'b1
  } writer_idx_t;

  // Degenerate extents of 1 still get a 1-bit field.
  function automatic int coord_w(input int extent);
    return (extent > 1) ? $clog2(extent) : 1;
  endfunction

  function automatic int addr_w(input int h, input int v);
    return coord_w(h * v);
  endfunction

endpackage

// File: rtl/fb_arbiter_if.sv
// Write-request bus shared by the CPU and blitter writers and the framebuffer arbiter.
interface fb_arbiter_if
  import fb_pkg::*;
#(
  parameter  int H_VISIBLE = DEF_H_VISIBLE,
  parameter  int V_VISIBLE = DEF_V_VISIBLE,
  parameter  int DATA_W    = DEF_DATA_W,
  localparam int XW        = coord_w(H_VISIBLE),
  localparam int YW        = coord_w(V_VISIBLE)
) ();

  logic [NUM_WRITERS-1:0]             wr_valid;
  logic [NUM_WRITERS-1:0]             wr_ready;
  logic [NUM_WRITERS-1:0][XW-1:0]     wr_x;
  logic [NUM_WRITERS-1:0][YW-1:0]     wr_y;
  logic [NUM_WRITERS-1:0][DATA_W-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_x,
    output wr_y,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_x,
    input  wr_y,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the last-grant pointer only moves when a grant is consumed.
module rr_arbiter2
  import fb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  writer_idx_t last_grant;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == WR_BLIT) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Reset to the blitter so the CPU wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= WR_BLIT;
    end else if (advance && (grant != 2'b00)) begin
      last_grant <= grant[1] ? WR_BLIT : WR_CPU;
    end
  end

endmodule

// File: rtl/fb_arbiter.sv
// Framebuffer RAM port arbiter: display reads take absolute priority, CPU/blitter
// writes share the remaining slots round-robin.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter  int H_VISIBLE   = DEF_H_VISIBLE,
  parameter  int V_VISIBLE   = DEF_V_VISIBLE,
  parameter  int DATA_W      = DEF_DATA_W,
  parameter  int VBLANK_ONLY = 0,
  localparam int XW          = coord_w(H_VISIBLE),
  localparam int YW          = coord_w(V_VISIBLE),
  localparam int AW          = addr_w(H_VISIBLE, V_VISIBLE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              visible_next,
  input  logic [XW-1:0]     position_x_next,
  input  logic [YW-1:0]     position_y_next,
  input  logic              vblank,
  fb_arbiter_if.slave       wr_bus,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  output logic              oob_err
);

  logic              display;
  logic              write_slot;
  logic [1:0]        req;
  logic [1:0]        grant;
  logic              transfer;
  writer_idx_t       sel;
  logic [XW-1:0]     sel_x;
  logic [YW-1:0]     sel_y;
  logic [DATA_W-1:0] sel_data;
  logic              sel_in_range;

  // Operands are widened to AW before the multiply so the product never truncates.
  function automatic logic [AW-1:0] pixel_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return AW'(y) * AW'(H_VISIBLE) + AW'(x);
  endfunction

  // rst_n gates the combinational strobes so every output drops the moment reset asserts.
  assign display    = rst_n & visible_next;
  assign write_slot = rst_n & ~visible_next & ((VBLANK_ONLY == 0) | vblank);
  assign req        = wr_bus.wr_valid & {2{write_slot}};

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .advance (transfer),
    .grant   (grant)
  );

  assign wr_bus.wr_ready = grant;
  assign transfer        = |grant;

  assign sel          = grant[1] ? WR_BLIT : WR_CPU;
  assign sel_x        = wr_bus.wr_x[sel];
  assign sel_y        = wr_bus.wr_y[sel];
  assign sel_data     = wr_bus.wr_data[sel];
  // One extra bit keeps the bound exact when the extent is a power of two.
  assign sel_in_range = ({1'b0, sel_x} < (XW + 1)'(H_VISIBLE)) &&
                        ({1'b0, sel_y} < (YW + 1)'(V_VISIBLE));

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (display) begin
      mem_en   = 1'b1;
      mem_addr = pixel_addr(position_x_next, position_y_next);
    end else if (transfer && sel_in_range) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = pixel_addr(sel_x, sel_y);
      mem_wdata = sel_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid <= 1'b0;
      oob_err   <= 1'b0;
    end else begin
      pix_valid <= visible_next;
      oob_err   <= oob_err | (transfer & ~sel_in_range);
    end
  end

  assign pix_data = pix_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: scoreboarded display reads and RAM writes plus per-scenario checks.
module tb_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        visible_next;
  logic        vblank;
  logic [9:0]  position_x_next;
  logic [8:0]  position_y_next;
  logic        mem_en, mem_we;
  logic [18:0] mem_addr;
  logic [11:0] mem_wdata, mem_rdata;
  logic        pix_valid;
  logic [11:0] pix_data;
  logic        oob_err;

  logic        vb_mem_en, vb_mem_we;
  logic [18:0] vb_mem_addr;
  logic [11:0] vb_mem_wdata;
  logic        vb_pix_valid;
  logic [11:0] vb_pix_data;
  logic        vb_oob_err;

  int checks = 0;
  int errors = 0;
  int model_last = 1;
  logic [11:0] pix_q[$];
  logic [30:0] wr_q[$];

  always #5 clk = ~clk;

  fb_arbiter_if #(.H_VISIBLE(640), .V_VISIBLE(480), .DATA_W(12)) wr_bus ();
  fb_arbiter_if #(.H_VISIBLE(640), .V_VISIBLE(480), .DATA_W(12)) wr_bus_vb ();

  assign wr_bus_vb.wr_valid = wr_bus.wr_valid;
  assign wr_bus_vb.wr_x     = wr_bus.wr_x;
  assign wr_bus_vb.wr_y     = wr_bus.wr_y;
  assign wr_bus_vb.wr_data  = wr_bus.wr_data;

  fb_arbiter #(.H_VISIBLE(640), .V_VISIBLE(480), .DATA_W(12), .VBLANK_ONLY(0)) dut (
    .clk(clk), .rst_n(rst_n), .visible_next(visible_next),
    .position_x_next(position_x_next), .position_y_next(position_y_next),
    .vblank(vblank), .wr_bus(wr_bus),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pix_valid(pix_valid), .pix_data(pix_data), .oob_err(oob_err)
  );

  fb_arbiter #(.H_VISIBLE(640), .V_VISIBLE(480), .DATA_W(12), .VBLANK_ONLY(1)) dut_vb (
    .clk(clk), .rst_n(rst_n), .visible_next(visible_next),
    .position_x_next(position_x_next), .position_y_next(position_y_next),
    .vblank(vblank), .wr_bus(wr_bus_vb),
    .mem_en(vb_mem_en), .mem_we(vb_mem_we), .mem_addr(vb_mem_addr), .mem_wdata(vb_mem_wdata),
    .mem_rdata(mem_rdata), .pix_valid(vb_pix_valid), .pix_data(vb_pix_data), .oob_err(vb_oob_err)
  );

  function automatic logic [11:0] ram_f(input logic [18:0] a);
    return a[11:0] ^ {a[18:13], 6'h2A};
  endfunction

  // RAM model with one-cycle read latency; idle cycles return a marker value.
  always @(posedge clk) begin
    mem_rdata <= (mem_en && !mem_we) ? ram_f(mem_addr) : 12'hA5A;
  end

  always @(posedge clk) begin
    if (rst_n && mem_en && mem_we) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write got addr=%0d data=%h want none", mem_addr, mem_wdata);
      end else begin
        logic [30:0] exp_w;
        exp_w = wr_q.pop_front();
        if ({mem_addr, mem_wdata} !== exp_w) begin
          errors++;
          $display("[TB] FAIL write_sb got addr=%0d data=%h want addr=%0d data=%h",
                   mem_addr, mem_wdata, exp_w[30:12], exp_w[11:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (pix_valid) begin
        if (pix_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_pixel got %h want none", pix_data);
        end else begin
          logic [11:0] exp_p;
          exp_p = pix_q.pop_front();
          if (pix_data !== exp_p) begin
            errors++;
            $display("[TB] FAIL pix_sb got %h want %h", pix_data, exp_p);
          end
        end
      end else if (pix_data !== 12'h000) begin
        errors++;
        $display("[TB] FAIL pix_idle got %h want 000", pix_data);
      end
    end
  end

  // Drives one cycle at the falling edge and records what the DUT owes in return.
  task automatic drive_cycle(input logic vis, input logic vb, input logic [1:0] valid,
                             input int x0, input int y0, input int x1, input int y1,
                             input logic [11:0] d0, input logic [11:0] d1,
                             input int px, input int py, output logic [1:0] exp_ready);
    int g, gx, gy;
    logic [11:0] gd;
    @(negedge clk);
    visible_next      = vis;
    vblank            = vb;
    position_x_next   = 10'(px);
    position_y_next   = 9'(py);
    wr_bus.wr_valid   = valid;
    wr_bus.wr_x[0]    = 10'(x0);
    wr_bus.wr_y[0]    = 9'(y0);
    wr_bus.wr_x[1]    = 10'(x1);
    wr_bus.wr_y[1]    = 9'(y1);
    wr_bus.wr_data[0] = d0;
    wr_bus.wr_data[1] = d1;
    exp_ready = 2'b00;
    if (vis) begin
      pix_q.push_back(ram_f(19'(py * 640 + px)));
    end else if (valid != 2'b00) begin
      g = (valid == 2'b11) ? ((model_last == 1) ? 0 : 1) : (valid[1] ? 1 : 0);
      exp_ready[g] = 1'b1;
      model_last = g;
      gx = (g == 1) ? x1 : x0;
      gy = (g == 1) ? y1 : y0;
      gd = (g == 1) ? d1 : d0;
      if (gx < 640 && gy < 480) wr_q.push_back({19'(gy * 640 + gx), gd});
    end
  endtask

  task automatic test_reset();
    visible_next = 1'b1;
    vblank = 1'b0;
    position_x_next = 10'd3;
    position_y_next = 9'd1;
    wr_bus.wr_valid = 2'b11;
    #2;
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_pix_valid got %b want 0", pix_valid); end
    checks++; if (pix_data !== 12'h000) begin errors++; $display("[TB] FAIL rst_pix_data got %h want 000", pix_data); end
    checks++; if (oob_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_oob got %b want 0", oob_err); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("[TB] FAIL rst_mem_en got %b want 0", mem_en); end
    checks++; if (wr_bus.wr_ready !== 2'b00) begin errors++; $display("[TB] FAIL rst_ready got %b want 00", wr_bus.wr_ready); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    visible_next = 1'b0;
    wr_bus.wr_valid = 2'b00;
    model_last = 1;
  endtask

  task automatic test_round_robin();
    logic [1:0] er;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b0, 1'b0, 2'b11, i, 1, 20 + i, 3, 12'h100 + 12'(i), 12'h200 + 12'(i), 0, 0, er);
      #1;
      checks++;
      if (wr_bus.wr_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("[TB] FAIL rr_grant[%0d] got %b want %b", i, wr_bus.wr_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      checks++;
      if (mem_we !== 1'b1) begin errors++; $display("[TB] FAIL rr_we[%0d] got %b want 1", i, mem_we); end
    end
  endtask

  task automatic test_display();
    logic [1:0] er;
    drive_cycle(1'b1, 1'b0, 2'b00, 0, 0, 0, 0, 12'h0, 12'h0, 5, 2, er);
    #1;
    checks++; if (mem_addr !== 19'd1285) begin errors++; $display("[TB] FAIL disp_addr got %0d want 1285", mem_addr); end
    checks++; if ({mem_en, mem_we} !== 2'b10) begin errors++; $display("[TB] FAIL disp_en_we got %b want 10", {mem_en, mem_we}); end
    drive_cycle(1'b1, 1'b0, 2'b00, 0, 0, 0, 0, 12'h0, 12'h0, 639, 479, er);
    #1;
    checks++; if (pix_valid !== 1'b1) begin errors++; $display("[TB] FAIL disp_pix_valid got %b want 1", pix_valid); end
    checks++; if (mem_addr !== 19'd307199) begin errors++; $display("[TB] FAIL disp_addr_max got %0d want 307199", mem_addr); end
    drive_cycle(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 12'h0, 12'h0, 0, 0, er);
    drive_cycle(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 12'h0, 12'h0, 0, 0, er);
    #1;
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("[TB] FAIL disp_pix_drop got %b want 0", pix_valid); end
  endtask

  task automatic test_display_priority();
    logic [1:0] er;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b0, 2'b01, 7, 7, 0, 0, 12'h777, 12'h0, 10 + i, 4, er);
      #1;
      checks++;
      if (wr_bus.wr_ready !== 2'b00) begin errors++; $display("[TB] FAIL prio_blocked[%0d] got %b want 00", i, wr_bus.wr_ready); end
    end
    drive_cycle(1'b0, 1'b0, 2'b01, 7, 7, 0, 0, 12'h777, 12'h0, 0, 0, er);
    #1;
    checks++; if (wr_bus.wr_ready !== er) begin errors++; $display("[TB] FAIL prio_release got %b want %b", wr_bus.wr_ready, er); end
  endtask

  task automatic test_vblank_only();
    logic [1:0] er;
    drive_cycle(1'b0, 1'b0, 2'b01, 30, 5, 0, 0, 12'h0F0, 12'h0, 0, 0, er);
    #1;
    checks++; if (wr_bus_vb.wr_ready !== 2'b00) begin errors++; $display("[TB] FAIL vbo_hblank got %b want 00", wr_bus_vb.wr_ready); end
    checks++; if (vb_mem_en !== 1'b0) begin errors++; $display("[TB] FAIL vbo_mem_en got %b want 0", vb_mem_en); end
    checks++; if (wr_bus.wr_ready !== er) begin errors++; $display("[TB] FAIL vbo_main got %b want %b", wr_bus.wr_ready, er); end
    drive_cycle(1'b0, 1'b1, 2'b01, 31, 5, 0, 0, 12'h0F1, 12'h0, 0, 0, er);
    #1;
    checks++; if (wr_bus_vb.wr_ready !== 2'b01) begin errors++; $display("[TB] FAIL vbo_vblank got %b want 01", wr_bus_vb.wr_ready); end
  endtask

  task automatic test_idle();
    logic [1:0] er;
    drive_cycle(1'b0, 1'b1, 2'b00, 100, 100, 200, 200, 12'hFFF, 12'hEEE, 0, 0, er);
    #1;
    checks++; if ({mem_en, mem_we} !== 2'b00) begin errors++; $display("[TB] FAIL idle_en_we got %b want 00", {mem_en, mem_we}); end
    checks++; if (mem_addr !== 19'd0) begin errors++; $display("[TB] FAIL idle_addr got %0d want 0", mem_addr); end
    checks++; if (mem_wdata !== 12'h000) begin errors++; $display("[TB] FAIL idle_wdata got %h want 000", mem_wdata); end
    checks++; if (wr_bus.wr_ready !== 2'b00) begin errors++; $display("[TB] FAIL idle_ready got %b want 00", wr_bus.wr_ready); end
  endtask

  task automatic test_oob();
    logic [1:0] er;
    drive_cycle(1'b0, 1'b0, 2'b01, 640, 0, 0, 0, 12'h3C3, 12'h0, 0, 0, er);
    #1;
    checks++; if (wr_bus.wr_ready !== 2'b01) begin errors++; $display("[TB] FAIL oob_ready got %b want 01", wr_bus.wr_ready); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("[TB] FAIL oob_mem_en got %b want 0", mem_en); end
    checks++; if (oob_err !== 1'b0) begin errors++; $display("[TB] FAIL oob_early got %b want 0", oob_err); end
    drive_cycle(1'b0, 1'b0, 2'b10, 0, 0, 639, 479, 12'h0, 12'h7E7, 0, 0, er);
    #1;
    checks++; if (oob_err !== 1'b1) begin errors++; $display("[TB] FAIL oob_set got %b want 1", oob_err); end
    checks++; if (mem_addr !== 19'd307199) begin errors++; $display("[TB] FAIL wr_addr_max got %0d want 307199", mem_addr); end
    checks++; if ({wr_bus.wr_ready, mem_we} !== 3'b101) begin errors++; $display("[TB] FAIL wr_max_rdy_we got %b want 101", {wr_bus.wr_ready, mem_we}); end
    drive_cycle(1'b0, 1'b0, 2'b01, 0, 480, 0, 0, 12'h111, 12'h0, 0, 0, er);
    #1;
    checks++; if ({wr_bus.wr_ready, mem_en} !== 3'b010) begin errors++; $display("[TB] FAIL oob_y got %b want 010", {wr_bus.wr_ready, mem_en}); end
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 12'h0, 12'h0, 0, 0, er);
    #1;
    checks++; if (oob_err !== 1'b1) begin errors++; $display("[TB] FAIL oob_sticky got %b want 1", oob_err); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] er;
    drive_cycle(1'b1, 1'b0, 2'b00, 0, 0, 0, 0, 12'h0, 12'h0, 7, 9, er);
    drive_cycle(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 12'h0, 12'h0, 0, 0, er);
    #1;
    checks++; if (pix_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre got %b want 1", pix_valid); end
    rst_n = 1'b0;
    visible_next = 1'b1;
    wr_bus.wr_valid = 2'b11;
    #1;
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_pix_valid got %b want 0", pix_valid); end
    checks++; if (oob_err !== 1'b0) begin errors++; $display("[TB] FAIL mid_oob got %b want 0", oob_err); end
    checks++; if ({mem_en, wr_bus.wr_ready} !== 3'b000) begin errors++; $display("[TB] FAIL mid_strobes got %b want 000", {mem_en, wr_bus.wr_ready}); end
    @(negedge clk);
    rst_n = 1'b1;
    visible_next = 1'b0;
    wr_bus.wr_valid = 2'b00;
    model_last = 1;
    drive_cycle(1'b0, 1'b0, 2'b11, 50, 60, 70, 80, 12'hABC, 12'hDEF, 0, 0, er);
    #1;
    checks++; if (wr_bus.wr_ready !== 2'b01) begin errors++; $display("[TB] FAIL mid_first_grant got %b want 01", wr_bus.wr_ready); end
    drive_cycle(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 12'h0, 12'h0, 0, 0, er);
    #1;
    checks++; if (oob_err !== 1'b0) begin errors++; $display("[TB] FAIL mid_oob_after got %b want 0", oob_err); end
  endtask

  initial begin
    rst_n = 1'b0;
    visible_next = 1'b0;
    vblank = 1'b0;
    position_x_next = '0;
    position_y_next = '0;
    wr_bus.wr_valid = 2'b00;
    wr_bus.wr_x = '0;
    wr_bus.wr_y = '0;
    wr_bus.wr_data = '0;
    $display("[TB] start");
    test_reset();
    test_round_robin();
    test_display();
    test_display_priority();
    test_vblank_only();
    test_idle();
    test_oob();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (pix_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_drain got pix=%0d wr=%0d want 0 0", pix_q.size(), wr_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 SHALL have parameter V_VISIBLE, default 480, visible lines per frame.
REQ-003 SHALL have parameter DATA_W, default 12, pixel width (RGB444).
REQ-004 SHALL have parameter VBLANK_ONLY, default 0; 1 = writes granted only while vblank is high.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 visible_next  in  1  from video timer: the next cycle is a visible pixel.
REQ-008 position_x_next / position_y_next  in  XW / YW  next visible pixel coordinate; XW = clog2(H_VISIBLE), YW = clog2(V_VISIBLE).
REQ-009 vblank  in  1  high while the vertical state is not visible.
REQ-010 wr_valid[1:0]  in  2  write request, one bit per writer (0 = CPU, 1 = blitter).
REQ-011 wr_x[i], wr_y[i], wr_data[i]  in  XW, YW, DATA_W  write coordinate and pixel, per writer.
REQ-012 wr_ready[1:0]  out  2  write accepted this cycle.
REQ-013 mem_en, mem_we  out  1, 1  RAM strobe and write enable; RAM has 1-cycle read latency.
REQ-014 mem_addr  out  AW  AW = clog2(H_VISIBLE*V_VISIBLE); mem_wdata  out  DATA_W; mem_rdata  in  DATA_W.
REQ-015 pix_valid, pix_data  out  1, DATA_W  pixel for the current visible cycle.
REQ-016 oob_err  out  1  sticky: an out-of-range write was accepted.

Function
REQ-017 Display has absolute priority: in any cycle with visible_next=1, SHALL drive mem_en=1, mem_we=0, mem_addr=position_y_next*H_VISIBLE+position_x_next, wr_ready=0.
REQ-018 pix_valid SHALL be visible_next registered (1-cycle latency); pix_data SHALL equal mem_rdata when pix_valid=1, else 0.
REQ-019 Write slot: a cycle with visible_next=0 and (VBLANK_ONLY=0 or vblank=1); outside a write slot, wr_ready=0.
REQ-020 In a write slot, SHALL grant at most one requester with wr_valid=1; wr_ready for that requester is 1 in the same cycle; a transfer occurs when wr_valid&wr_ready.
REQ-021 Arbitration SHALL be round-robin: if both request, grant the one not granted last; last_grant updates only on a transfer.
REQ-022 In-range transfer: mem_en=1, mem_we=1, mem_addr=wr_y*H_VISIBLE+wr_x, mem_wdata=wr_data of the granted writer.
REQ-023 Out-of-range transfer (wr_x>=H_VISIBLE or wr_y>=V_VISIBLE): SHALL accept (wr_ready=1), keep mem_en=0, and set oob_err on the next edge.
REQ-024 No request or no slot: mem_en=0, mem_we=0; mem_addr and mem_wdata SHALL be 0.
REQ-025 Address arithmetic SHALL be carried out at AW bits without truncation for all in-range coordinates; max address = H_VISIBLE*V_VISIBLE-1.
REQ-026 A writer holding wr_valid with wr_ready=0 SHALL be served within 2 write slots (no starvation).
REQ-027 wr_ready SHALL be combinational from wr_valid, visible_next, vblank, and last_grant only.

Reset
REQ-028 While rst_n=0: pix_valid=0, pix_data=0, oob_err=0, last_grant=1 (writer 0 wins the first contention), and all outputs deasserted asynchronously.
REQ-029 Reset mid-frame SHALL drop pix_valid immediately; after release, behaviour depends only on the current inputs (no replay of pending requests).
REQ-030 oob_err SHALL clear only on reset.

Structure
REQ-031 Package fb_pkg SHALL hold DATA_W, H_VISIBLE and V_VISIBLE defaults, the XW/YW/AW derivations, and the writer-index typedef.
REQ-032 Round-robin logic SHALL be the sub-module rr_arbiter2 (req[1:0], advance, grant[1:0], last-grant register inside).

Verification
REQ-033 visible_next=1, x=5, y=2 -> mem_addr=1285, mem_we=0; next cycle pix_valid=1, pix_data=mem_rdata.
REQ-034 Both writers valid during 6 blanking cycles -> grants 0,1,0,1,0,1; mem_we=1 each cycle.
REQ-035 Writer 0 valid while visible_next=1 -> wr_ready=0 until visible_next=0, then granted that cycle.
REQ-036 VBLANK_ONLY=1, horizontal blank with vblank=0, write valid -> wr_ready=0; vblank=1 -> granted.
REQ-037 Write x=640, y=0 -> wr_ready=1, mem_en=0, oob_err=1 next cycle; write x=639, y=479 -> mem_addr=307199.
REQ-038 rst_n low mid-line with pix_valid=1 -> pix_valid=0 and oob_err=0 without a clock edge; first contention after release grants writer 0.
